// File: rtl/halt_pkg.sv
// Shared types and opcode constants for the halt/drain controller.
package halt_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_BREAK    = 2'd1,
    CAUSE_SYSCALL  = 2'd2,
    CAUSE_EXT_STEP = 2'd3
  } cause_e;

  localparam int unsigned OP_W = 6;
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] FN_BREAK   = 6'h0D;
  localparam logic [OP_W-1:0] FN_SYSCALL = 6'h0C;

endpackage

// File: rtl/halt_controller_if.sv
// Issue-side request and halt-status bundle between the core and the halt controller.
interface halt_controller_if #(
  parameter int unsigned IR_W         = 32,
  parameter int unsigned DRAIN_CYCLES = 4
);
  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  logic             ir_valid;
  logic [IR_W-1:0]  IR;
  logic             ext_halt;
  logic             step_en;
  logic             resume;
  logic             fetch_stall;
  logic             done;
  logic [1:0]       halt_cause;
  logic             halt_step;
  logic [CNT_W-1:0] drain_count;

  modport master (
    output ir_valid, IR, ext_halt, step_en, resume,
    input  fetch_stall, done, halt_cause, halt_step, drain_count
  );

  modport slave (
    input  ir_valid, IR, ext_halt, step_en, resume,
    output fetch_stall, done, halt_cause, halt_step, drain_count
  );
endinterface

// File: rtl/halt_trigger_decode.sv
// Combinational halt-trigger detection with priority ext_halt > BREAK > SYSCALL > STEP.
module halt_trigger_decode
  import halt_pkg::*;
#(
  parameter int unsigned IR_W            = 32,
  parameter int unsigned HALT_ON_SYSCALL = 0,
  parameter int unsigned STRICT_BREAK    = 0
) (
  input  logic [IR_W-1:0] i_ir,
  input  logic            i_ir_valid,
  input  logic            i_ext_halt,
  input  logic            i_step_en,
  output logic            o_trig,
  output cause_e          o_cause,
  output logic            o_step
);

  logic [OP_W-1:0] w_opcode;
  logic [OP_W-1:0] w_funct;
  logic            w_special;
  logic            w_break_loose;
  logic            w_break_strict;
  logic            w_is_break;
  logic            w_is_syscall;
  logic            w_is_step;

  assign w_opcode       = i_ir[IR_W-1 -: OP_W];
  assign w_funct        = i_ir[OP_W-1:0];
  assign w_special      = (w_opcode == OP_SPECIAL);
  assign w_break_loose  = w_special && (w_funct == FN_BREAK);
  assign w_break_strict = (i_ir == IR_W'(32'h0000_000D));
  assign w_is_break     = i_ir_valid && ((STRICT_BREAK != 0) ? w_break_strict : w_break_loose);
  assign w_is_syscall   = i_ir_valid && (HALT_ON_SYSCALL != 0) && w_special && (w_funct == FN_SYSCALL);
  assign w_is_step      = i_ir_valid && i_step_en;

  always_comb begin
    o_trig  = 1'b0;
    o_cause = CAUSE_NONE;
    o_step  = 1'b0;
    if (i_ext_halt) begin
      o_trig  = 1'b1;
      o_cause = CAUSE_EXT_STEP;
    end else if (w_is_break) begin
      o_trig  = 1'b1;
      o_cause = CAUSE_BREAK;
    end else if (w_is_syscall) begin
      o_trig  = 1'b1;
      o_cause = CAUSE_SYSCALL;
    end else if (w_is_step) begin
      o_trig  = 1'b1;
      o_cause = CAUSE_EXT_STEP;
      o_step  = 1'b1;
    end
  end

endmodule

// File: rtl/halt_controller.sv
// Halt/drain controller: freezes fetch on a trigger, drains in-flight work, holds halted until resume.
module halt_controller
  import halt_pkg::*;
#(
  parameter int unsigned IR_W            = 32,
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter int unsigned HALT_ON_SYSCALL = 0,
  parameter int unsigned STRICT_BREAK    = 0
) (
  input logic              clk,
  input logic              rst,
  halt_controller_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_e           r_state;
  logic             r_fetch_stall;
  logic             r_done;
  cause_e           r_halt_cause;
  logic             r_halt_step;
  logic [CNT_W-1:0] r_drain_count;

  logic             w_trig;
  cause_e           w_cause;
  logic             w_step;

  halt_trigger_decode #(
    .IR_W            (IR_W),
    .HALT_ON_SYSCALL (HALT_ON_SYSCALL),
    .STRICT_BREAK    (STRICT_BREAK)
  ) u_decode (
    .i_ir       (bus.IR),
    .i_ir_valid (bus.ir_valid),
    .i_ext_halt (bus.ext_halt),
    .i_step_en  (bus.step_en),
    .o_trig     (w_trig),
    .o_cause    (w_cause),
    .o_step     (w_step)
  );

  // Triggers are only honoured in RUN; resume is only honoured in HALTED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_fetch_stall <= 1'b0;
      r_done        <= 1'b0;
      r_halt_cause  <= CAUSE_NONE;
      r_halt_step   <= 1'b0;
      r_drain_count <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_trig) begin
            r_state       <= ST_DRAIN;
            r_fetch_stall <= 1'b1;
            r_drain_count <= '0;
            r_halt_cause  <= w_cause;
            r_halt_step   <= w_step;
          end
        end
        ST_DRAIN: begin
          if (r_drain_count == CNT_W'(DRAIN_CYCLES - 1)) begin
            r_state       <= ST_HALTED;
            r_done        <= 1'b1;
            r_drain_count <= CNT_W'(DRAIN_CYCLES);
          end else begin
            r_drain_count <= r_drain_count + CNT_W'(1);
          end
        end
        ST_HALTED: begin
          if (bus.resume) begin
            r_state       <= ST_RUN;
            r_fetch_stall <= 1'b0;
            r_done        <= 1'b0;
            r_drain_count <= '0;
            r_halt_cause  <= CAUSE_NONE;
            r_halt_step   <= 1'b0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.fetch_stall = r_fetch_stall;
  assign bus.done        = r_done;
  assign bus.halt_cause  = r_halt_cause;
  assign bus.halt_step   = r_halt_step;
  assign bus.drain_count = r_drain_count;

endmodule

// File: tb/tb_halt_controller.sv
// Directed bench for halt_controller across default, strict-BREAK and one-cycle-drain configurations.
module tb_halt_controller;

  logic clk;
  logic rst;

  halt_controller_if #(.IR_W(32), .DRAIN_CYCLES(4)) if_d ();
  halt_controller_if #(.IR_W(32), .DRAIN_CYCLES(4)) if_s ();
  halt_controller_if #(.IR_W(32), .DRAIN_CYCLES(1)) if_q ();

  halt_controller #(.IR_W(32), .DRAIN_CYCLES(4), .HALT_ON_SYSCALL(0), .STRICT_BREAK(0))
    u_d (.clk(clk), .rst(rst), .bus(if_d.slave));
  halt_controller #(.IR_W(32), .DRAIN_CYCLES(4), .HALT_ON_SYSCALL(0), .STRICT_BREAK(1))
    u_s (.clk(clk), .rst(rst), .bus(if_s.slave));
  halt_controller #(.IR_W(32), .DRAIN_CYCLES(1), .HALT_ON_SYSCALL(1), .STRICT_BREAK(0))
    u_q (.clk(clk), .rst(rst), .bus(if_q.slave));

  // Packed view {fetch_stall, done, halt_cause, halt_step, drain_count}
  logic [7:0] obs_d, obs_s, e8;
  logic [5:0] obs_q, e6;
  assign obs_d = {if_d.fetch_stall, if_d.done, if_d.halt_cause, if_d.halt_step, if_d.drain_count};
  assign obs_s = {if_s.fetch_stall, if_s.done, if_s.halt_cause, if_s.halt_step, if_s.drain_count};
  assign obs_q = {if_q.fetch_stall, if_q.done, if_q.halt_cause, if_q.halt_step, if_q.drain_count};

  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_total++; if (obs_d !== 8'h00) $display("FAIL reset_d got=%h want=00", obs_d); else n_pass++;
    n_total++; if (obs_s !== 8'h00) $display("FAIL reset_s got=%h want=00", obs_s); else n_pass++;
    n_total++; if (obs_q !== 6'h00) $display("FAIL reset_q got=%h want=00", obs_q); else n_pass++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_break_default();
    if_d.IR = 32'h0000_000D; if_d.ir_valid = 1'b1;
    tick();
    if_d.ir_valid = 1'b0;
    e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'd0};
    n_total++; if (obs_d !== e8) $display("FAIL brk_trig got=%h want=%h", obs_d, e8); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'(k)};
      n_total++; if (obs_d !== e8) $display("FAIL brk_drain[%0d] got=%h want=%h", k, obs_d, e8); else n_pass++;
    end
    tick();
    e8 = {1'b1, 1'b1, 2'd1, 1'b0, 3'd4};
    n_total++; if (obs_d !== e8) $display("FAIL brk_done got=%h want=%h", obs_d, e8); else n_pass++;
    tick();
    tick();
    n_total++; if (obs_d !== e8) $display("FAIL brk_hold got=%h want=%h", obs_d, e8); else n_pass++;
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
    n_total++; if (obs_d !== 8'h00) $display("FAIL brk_resume got=%h want=00", obs_d); else n_pass++;
    tick();
    n_total++; if (obs_d !== 8'h00) $display("FAIL brk_stay_run got=%h want=00", obs_d); else n_pass++;
  endtask

  task automatic test_break_code();
    if_d.IR = 32'h03FF_FFCD; if_d.ir_valid = 1'b1;
    if_s.IR = 32'h03FF_FFCD; if_s.ir_valid = 1'b1;
    tick();
    if_d.ir_valid = 1'b0; if_s.ir_valid = 1'b0;
    e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'd0};
    n_total++; if (obs_d !== e8) $display("FAIL code_loose got=%h want=%h", obs_d, e8); else n_pass++;
    n_total++; if (obs_s !== 8'h00) $display("FAIL code_strict got=%h want=00", obs_s); else n_pass++;
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
    e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'd1};
    n_total++; if (obs_d !== e8) $display("FAIL resume_in_drain got=%h want=%h", obs_d, e8); else n_pass++;
    tick(); tick(); tick();
    e8 = {1'b1, 1'b1, 2'd1, 1'b0, 3'd4};
    n_total++; if (obs_d !== e8) $display("FAIL code_done got=%h want=%h", obs_d, e8); else n_pass++;
    n_total++; if (obs_s !== 8'h00) $display("FAIL code_strict_idle got=%h want=00", obs_s); else n_pass++;
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
    if_s.IR = 32'h0000_000D; if_s.ir_valid = 1'b1;
    tick();
    if_s.ir_valid = 1'b0;
    e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'd0};
    n_total++; if (obs_s !== e8) $display("FAIL strict_exact got=%h want=%h", obs_s, e8); else n_pass++;
    tick(); tick(); tick(); tick();
    e8 = {1'b1, 1'b1, 2'd1, 1'b0, 3'd4};
    n_total++; if (obs_s !== e8) $display("FAIL strict_done got=%h want=%h", obs_s, e8); else n_pass++;
    if_s.resume = 1'b1;
    tick();
    if_s.resume = 1'b0;
    n_total++; if (obs_s !== 8'h00) $display("FAIL strict_resume got=%h want=00", obs_s); else n_pass++;
  endtask

  task automatic test_syscall_ext();
    if_q.IR = 32'h0000_000C; if_q.ir_valid = 1'b1; if_q.ext_halt = 1'b1;
    if_d.IR = 32'h0000_000C; if_d.ir_valid = 1'b1;
    tick();
    if_q.ir_valid = 1'b0; if_q.ext_halt = 1'b0; if_d.ir_valid = 1'b0;
    e6 = {1'b1, 1'b0, 2'd3, 1'b0, 1'b0};
    n_total++; if (obs_q !== e6) $display("FAIL ext_over_sys got=%h want=%h", obs_q, e6); else n_pass++;
    n_total++; if (obs_d !== 8'h00) $display("FAIL sys_disabled got=%h want=00", obs_d); else n_pass++;
    tick();
    e6 = {1'b1, 1'b1, 2'd3, 1'b0, 1'b1};
    n_total++; if (obs_q !== e6) $display("FAIL d1_done got=%h want=%h", obs_q, e6); else n_pass++;
    if_q.resume = 1'b1;
    tick();
    if_q.resume = 1'b0;
    n_total++; if (obs_q !== 6'h00) $display("FAIL d1_resume got=%h want=00", obs_q); else n_pass++;
    if_q.ir_valid = 1'b1;
    tick();
    if_q.ir_valid = 1'b0;
    e6 = {1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    n_total++; if (obs_q !== e6) $display("FAIL sys_trig got=%h want=%h", obs_q, e6); else n_pass++;
    tick();
    e6 = {1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    n_total++; if (obs_q !== e6) $display("FAIL sys_done got=%h want=%h", obs_q, e6); else n_pass++;
    if_q.resume = 1'b1;
    tick();
    if_q.resume = 1'b0;
    n_total++; if (obs_q !== 6'h00) $display("FAIL sys_resume got=%h want=00", obs_q); else n_pass++;
  endtask

  task automatic test_step();
    if_d.step_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_d.IR = 32'h0128_5020; if_d.ir_valid = 1'b1;
      tick();
      if_d.ir_valid = 1'b0;
      e8 = {1'b1, 1'b0, 2'd3, 1'b1, 3'd0};
      n_total++; if (obs_d !== e8) $display("FAIL step_trig[%0d] got=%h want=%h", i, obs_d, e8); else n_pass++;
      if (i == 0) begin
        if_d.IR = 32'h0000_000D; if_d.ir_valid = 1'b1;
      end
      tick();
      if_d.ir_valid = 1'b0;
      tick(); tick(); tick();
      e8 = {1'b1, 1'b1, 2'd3, 1'b1, 3'd4};
      n_total++; if (obs_d !== e8) $display("FAIL step_done[%0d] got=%h want=%h", i, obs_d, e8); else n_pass++;
      tick();
      if_d.resume = 1'b1;
      tick();
      if_d.resume = 1'b0;
      n_total++; if (obs_d !== 8'h00) $display("FAIL step_resume[%0d] got=%h want=00", i, obs_d); else n_pass++;
    end
    if_d.step_en = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    if_d.IR = 32'h0000_000D; if_d.ir_valid = 1'b1;
    tick();
    if_d.ir_valid = 1'b0;
    tick(); tick();
    e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'd2};
    n_total++; if (obs_d !== e8) $display("FAIL pre_rst got=%h want=%h", obs_d, e8); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if (obs_d !== 8'h00) $display("FAIL async_rst got=%h want=00", obs_d); else n_pass++;
    tick();
    rst = 1'b1;
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
    n_total++; if (obs_d !== 8'h00) $display("FAIL resume_in_run got=%h want=00", obs_d); else n_pass++;
    if_d.ir_valid = 1'b1;
    tick();
    if_d.ir_valid = 1'b0;
    tick(); tick(); tick();
    e8 = {1'b1, 1'b0, 2'd1, 1'b0, 3'd3};
    n_total++; if (obs_d !== e8) $display("FAIL rst_recount got=%h want=%h", obs_d, e8); else n_pass++;
    tick();
    e8 = {1'b1, 1'b1, 2'd1, 1'b0, 3'd4};
    n_total++; if (obs_d !== e8) $display("FAIL rst_redone got=%h want=%h", obs_d, e8); else n_pass++;
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
  endtask

  task automatic test_resume_with_ext();
    if_d.ext_halt = 1'b1;
    tick();
    tick(); tick(); tick(); tick();
    e8 = {1'b1, 1'b1, 2'd3, 1'b0, 3'd4};
    n_total++; if (obs_d !== e8) $display("FAIL ext_done got=%h want=%h", obs_d, e8); else n_pass++;
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
    n_total++; if (obs_d !== 8'h00) $display("FAIL ext_resume_wins got=%h want=00", obs_d); else n_pass++;
    tick();
    e8 = {1'b1, 1'b0, 2'd3, 1'b0, 3'd0};
    n_total++; if (obs_d !== e8) $display("FAIL ext_retrigger got=%h want=%h", obs_d, e8); else n_pass++;
    if_d.ext_halt = 1'b0;
    tick(); tick(); tick(); tick();
    if_d.resume = 1'b1;
    tick();
    if_d.resume = 1'b0;
    n_total++; if (obs_d !== 8'h00) $display("FAIL ext_final got=%h want=00", obs_d); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b0;
    if_d.ir_valid = 1'b0; if_d.IR = '0; if_d.ext_halt = 1'b0; if_d.step_en = 1'b0; if_d.resume = 1'b0;
    if_s.ir_valid = 1'b0; if_s.IR = '0; if_s.ext_halt = 1'b0; if_s.step_en = 1'b0; if_s.resume = 1'b0;
    if_q.ir_valid = 1'b0; if_q.IR = '0; if_q.ext_halt = 1'b0; if_q.step_en = 1'b0; if_q.resume = 1'b0;
    test_reset();
    test_break_default();
    test_break_code();
    test_syscall_ext();
    test_step();
    test_reset_mid_drain();
    test_resume_with_ext();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
